a2d_spi_slave_model: RTL and testbench

Parametrised, synthesisable SPI A2D slave that implements the ADC128S-compatible 16-bit frame protocol, generalised to NUM_CH channels of RES-bit data. Channel values come from a packed input bus or from an internal per-channel ramp generator. It sits on the A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO pins of the Segway DUT in full-chip benches and on FPGA loop-back rigs. It replaces ad-hoc load-cell/battery wrappers.

---
 rtl/a2d_spi_slave_model_pkg.sv | 15 +
 rtl/a2d_spi_slave_model_if.sv | 12 +
 rtl/a2d_spi_slave_model_sync.sv | 36 +++
 rtl/a2d_spi_slave_model.sv | 163 ++++++++++++++++
 tb/tb_a2d_spi_slave_model.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/a2d_spi_slave_model_pkg.sv
// Shared types and frame-format constants for the A2D SPI slave model.
package a2d_model_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_SS
    } state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned ADDR_HI    = 13;
    localparam int unsigned ADDR_LO    = 11;
    localparam int unsigned DATA_W     = 12;

endpackage

// File: rtl/a2d_spi_slave_model_if.sv
// SPI pin bundle between an A2D master and the slave model.
interface a2d_spi_if;

    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);

endinterface

// File: rtl/a2d_spi_slave_model_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with one-clk rise/fall pulses.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
            s3_q <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: rtl/a2d_spi_slave_model.sv
// ADC128S-style 16-bit frame SPI slave with NUM_CH channels of RES-bit data,
// sourced from a static bus or per-channel ramp registers.
module a2d_spi_slave_model
    import a2d_model_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned RES    = 12,
    parameter int unsigned STEP   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    a2d_spi_if.slave              spi,
    input  logic [NUM_CH*RES-1:0] ch_data,
    input  logic                  ramp_mode,
    output logic                  frame_done,
    output logic [2:0]            last_ch,
    output logic                  addr_err
);

    logic ss_rise, ss_fall, sclk_rise, sclk_fall;

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.SS_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi.SCLK),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [ADDR_HI:0]        rx_q, rx_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [2:0]              cur_ch_q, cur_ch_d;
    logic [2:0]              last_ch_q, last_ch_d;
    logic                    addr_err_q, addr_err_d;
    logic                    frame_done_q, frame_done_d;
    logic                    miso_q, miso_d;
    logic                    mosi_s1_q, mosi_s1_d;
    logic                    mosi_s2_q, mosi_s2_d;
    logic [RES-1:0]          ramp_q [NUM_CH];
    logic [RES-1:0]          ramp_d [NUM_CH];

    logic [RES-1:0]          sel_val;
    logic [FRAME_BITS-1:0]   load_word;
    logic [2:0]              rx_addr;

    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (cur_ch_q == 3'(k)) begin
                sel_val = ramp_mode ? ramp_q[k] : ch_data[k*RES +: RES];
            end
        end
        load_word = {4'b0000, DATA_W'(sel_val) << (DATA_W - RES)};
        rx_addr   = rx_q[ADDR_HI:ADDR_LO];
    end

    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        cnt_d        = cnt_q;
        cur_ch_d     = cur_ch_q;
        last_ch_d    = last_ch_q;
        addr_err_d   = addr_err_q;
        frame_done_d = 1'b0;
        ramp_d       = ramp_q;
        mosi_s1_d    = spi.MOSI;
        mosi_s2_d    = mosi_s1_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d    = load_word;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    // rx only keeps bits up to the address MSB; older bits fall off.
                    rx_d  = {rx_q[ADDR_HI-1:0], mosi_s2_q};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_d == 5'(FRAME_BITS)) begin
                        state_d = WAIT_SS;
                    end
                end else if (sclk_fall && (cnt_q != '0)) begin
                    // The lead-in fall before the first rise must not discard the MSB.
                    tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            WAIT_SS: begin
                if (ss_rise) begin
                    state_d      = IDLE;
                    cur_ch_d     = rx_addr;
                    last_ch_d    = rx_addr;
                    frame_done_d = 1'b1;
                    if ({1'b0, rx_addr} >= 4'(NUM_CH)) begin
                        addr_err_d = 1'b1;
                    end
                    if (ramp_mode) begin
                        for (int unsigned k = 0; k < NUM_CH; k++) begin
                            if (cur_ch_q == 3'(k)) begin
                                ramp_d[k] = ramp_q[k] + RES'(STEP);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        miso_d = (state_d == IDLE) ? 1'b0 : tx_d[FRAME_BITS-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tx_q         <= '0;
            rx_q         <= '0;
            cnt_q        <= '0;
            cur_ch_q     <= '0;
            last_ch_q    <= '0;
            addr_err_q   <= 1'b0;
            frame_done_q <= 1'b0;
            miso_q       <= 1'b0;
            mosi_s1_q    <= 1'b0;
            mosi_s2_q    <= 1'b0;
            ramp_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            cnt_q        <= cnt_d;
            cur_ch_q     <= cur_ch_d;
            last_ch_q    <= last_ch_d;
            addr_err_q   <= addr_err_d;
            frame_done_q <= frame_done_d;
            miso_q       <= miso_d;
            mosi_s1_q    <= mosi_s1_d;
            mosi_s2_q    <= mosi_s2_d;
            ramp_q       <= ramp_d;
        end
    end

    assign spi.MISO   = miso_q;
    assign frame_done = frame_done_q;
    assign last_ch    = last_ch_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_a2d_spi_slave_model.sv
// Directed bench for a2d_spi_slave_model: three parameterisations on separate SS_n lines.
module tb_a2d_spi_slave_model;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] ss_n = 3'b111;
    logic sclk = 1'b1;
    logic mosi = 1'b0;
    logic [2:0] miso_v;
    logic [2:0] fd;
    logic [2:0] aerr;
    logic [2:0] lc0, lc1, lc2;
    int fd_cnt [3];
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    logic [95:0] data0;
    logic [29:0] data1;
    logic [95:0] data2;

    a2d_spi_if bus0 ();
    a2d_spi_if bus1 ();
    a2d_spi_if bus2 ();

    assign bus0.SS_n = ss_n[0];
    assign bus1.SS_n = ss_n[1];
    assign bus2.SS_n = ss_n[2];
    assign bus0.SCLK = sclk;
    assign bus1.SCLK = sclk;
    assign bus2.SCLK = sclk;
    assign bus0.MOSI = mosi;
    assign bus1.MOSI = mosi;
    assign bus2.MOSI = mosi;
    assign miso_v = {bus2.MISO, bus1.MISO, bus0.MISO};

    assign data0 = {12'h000, 12'h000, 12'h000, 12'h000, 12'hC35, 12'h7E1, 12'h1A0, 12'h1A6};
    assign data1 = {10'h001, 10'h155, 10'h3FF};
    assign data2 = {84'h0, 12'h5A5};

    a2d_spi_slave_model #(.NUM_CH(8), .RES(12), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .spi(bus0), .ch_data(data0), .ramp_mode(1'b0),
        .frame_done(fd[0]), .last_ch(lc0), .addr_err(aerr[0])
    );

    a2d_spi_slave_model #(.NUM_CH(3), .RES(10), .STEP(1)) u1 (
        .clk(clk), .rst(rst), .spi(bus1), .ch_data(data1), .ramp_mode(1'b0),
        .frame_done(fd[1]), .last_ch(lc1), .addr_err(aerr[1])
    );

    a2d_spi_slave_model #(.NUM_CH(8), .RES(12), .STEP(32'h800)) u2 (
        .clk(clk), .rst(rst), .spi(bus2), .ch_data(data2), .ramp_mode(1'b1),
        .frame_done(fd[2]), .last_ch(lc2), .addr_err(aerr[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (fd[i]) fd_cnt[i] <= fd_cnt[i] + 1;
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Master shifts MOSI on SCLK fall and samples MISO just before each rise.
    task automatic spi_frame(input int d, input logic [15:0] cmd, input int nbits,
                             input bit close, output logic [15:0] rxw);
        rxw = '0;
        @(negedge clk);
        ss_n[d] = 1'b0;
        wait_clks(6);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = cmd[15-i];
            wait_clks(6);
            rxw = {rxw[14:0], miso_v[d]};
            sclk = 1'b1;
            wait_clks(6);
        end
        if (close) begin
            ss_n[d] = 1'b1;
            wait_clks(8);
        end
    endtask

    task automatic xfer(input int d, input int addr, input logic [15:0] expw);
        logic [15:0] got;
        logic [15:0] want;
        logic [15:0] cmd;
        cmd = 16'(addr) << 11;
        exp_q.push_back(expw);
        spi_frame(d, cmd, 16, 1'b1, got);
        want = exp_q.pop_front();
        check($sformatf("u%0d word addr%0d", d, addr), 32'(got), 32'(want));
    endtask

    initial begin
        logic [15:0] junk;
        wait_clks(5);
        rst = 1'b0;
        wait_clks(4);

        check("u0 reset miso", 32'(miso_v[0]), 0);
        check("u0 reset frame_done", 32'(fd[0]), 0);
        check("u0 reset last_ch", 32'(lc0), 0);
        check("u0 reset addr_err", 32'(aerr[0]), 0);

        // Pipelined channel select, static data
        xfer(0, 1, 16'h01A6);
        xfer(0, 0, 16'h01A0);
        check("u0 last_ch after 2", 32'(lc0), 0);
        check("u0 fd count 2", 32'(fd_cnt[0]), 2);
        xfer(0, 3, 16'h01A6);
        check("u0 last_ch 3", 32'(lc0), 3);
        check("u0 miso idle", 32'(miso_v[0]), 0);

        // Aborted frame after 9 SCLKs leaves cur_ch at 3
        spi_frame(0, 16'(4) << 11, 9, 1'b1, junk);
        check("u0 abort no pulse", 32'(fd_cnt[0]), 3);
        check("u0 abort last_ch", 32'(lc0), 3);
        xfer(0, 0, 16'h0C35);
        check("u0 fd count 4", 32'(fd_cnt[0]), 4);

        // RES=10 left-justification, illegal channel, sticky addr_err
        xfer(1, 5, 16'h0FFC);
        check("u1 addr_err set", 32'(aerr[1]), 1);
        check("u1 last_ch 5", 32'(lc1), 5);
        xfer(1, 2, 16'h0000);
        check("u1 addr_err sticky", 32'(aerr[1]), 1);
        xfer(1, 1, 16'h0004);
        check("u1 addr_err stays", 32'(aerr[1]), 1);
        check("u1 fd count", 32'(fd_cnt[1]), 3);

        // Ramp mode, STEP=0x800
        xfer(2, 2, 16'h0000);
        xfer(2, 2, 16'h0000);
        xfer(2, 2, 16'h0800);
        xfer(2, 2, 16'h0000);
        xfer(2, 1, 16'h0800);
        xfer(2, 0, 16'h0000);
        xfer(2, 0, 16'h0800);
        check("u2 addr_err clear", 32'(aerr[2]), 0);

        // Asynchronous reset in the middle of a shifting frame
        xfer(0, 1, 16'h01A6);
        spi_frame(0, 16'(5) << 11, 5, 1'b0, junk);
        rst = 1'b1;
        #1;
        check("u0 rst miso", 32'(miso_v[0]), 0);
        check("u0 rst last_ch", 32'(lc0), 0);
        ss_n[0] = 1'b1;
        sclk = 1'b1;
        wait_clks(6);
        rst = 1'b0;
        wait_clks(6);
        check("u0 post-rst fd count", 32'(fd_cnt[0]), 5);
        xfer(0, 2, 16'h01A6);
        check("u0 post-rst last_ch", 32'(lc0), 2);
        check("u0 post-rst fd", 32'(fd_cnt[0]), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
